// File: rtl/spi_cmd_pkg.sv
// Shared widths, opcodes and RX state encoding for the SPI command bridge.
package spi_cmd_pkg;

  localparam int OPCODE_W  = 8;
  localparam int PAYLOAD_W = 24;
  localparam int RX_WORD_W = 32;

  localparam logic [OPCODE_W-1:0] OP_NOP         = 8'h00;
  localparam logic [OPCODE_W-1:0] OP_INIT        = 8'h01;
  localparam logic [OPCODE_W-1:0] OP_WR_INVERTED = 8'h02;
  localparam logic [OPCODE_W-1:0] OP_RD_INVERTED = 8'h03;
  localparam logic [OPCODE_W-1:0] OP_WR_LEDS     = 8'h04;
  localparam logic [OPCODE_W-1:0] OP_RD_LEDS     = 8'h05;
  localparam logic [OPCODE_W-1:0] OP_WR_VEC      = 8'h06;
  localparam logic [OPCODE_W-1:0] OP_RD_VEC      = 8'h07;

  typedef enum logic [0:0] {
    RX_IDLE     = 1'b0,
    RX_WAIT_LOW = 1'b1
  } rx_state_e;

  function automatic logic is_queued_opcode(input logic [OPCODE_W-1:0] op);
    return (op != OP_NOP) && (op != OP_INIT);
  endfunction

endpackage

// File: rtl/spi_cmd_bridge_fifo.sv
// First-word fall-through synchronous FIFO with flush; head is read straight from storage.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && (count_q != FULL_CNT);
  assign pop_ok  = pop_i && (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage is cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/spi_cmd_bridge.sv
// Bridges SPI slave words to a command stream (NOP filtered, INIT flushes) and meters
// handler responses back into the slave's transmit port.
module spi_cmd_bridge
  import spi_cmd_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_rd_data_available,
  input  logic [RX_WORD_W-1:0] spi_rd_data,
  output logic                 spi_rd_ack,
  input  logic                 spi_wr_buffer_free,
  output logic                 spi_wr_en,
  output logic [PAYLOAD_W-1:0] spi_wr_data,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [OPCODE_W-1:0]  cmd_opcode,
  output logic [PAYLOAD_W-1:0] cmd_payload,
  input  logic                 rsp_valid,
  output logic                 rsp_ready,
  input  logic [PAYLOAD_W-1:0] rsp_data,
  output logic                 init_pulse
);

  localparam int CCW = $clog2(CMD_DEPTH) + 1;
  localparam int RCW = $clog2(RSP_DEPTH) + 1;
  localparam logic [CCW-1:0] CMD_FULL = CCW'(CMD_DEPTH);
  localparam logic [RCW-1:0] RSP_FULL = RCW'(RSP_DEPTH);

  rx_state_e            state_q;
  logic                 rd_ack_q;
  logic                 init_q;
  logic                 push_q;
  logic [RX_WORD_W-1:0] push_word_q;
  logic                 wr_en_q;
  logic                 wr_en_d;
  logic [PAYLOAD_W-1:0] wr_data_q;

  logic [CCW-1:0]       cmd_count;
  logic [RX_WORD_W-1:0] cmd_head;
  logic [RCW-1:0]       rsp_count;
  logic [PAYLOAD_W-1:0] rsp_head;
  logic [OPCODE_W-1:0]  rx_opcode;

  assign rx_opcode = spi_rd_data[OPCODE_W-1:0];

  // RX capture: the push and the flush both land one edge after the ack is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RX_IDLE;
      rd_ack_q    <= 1'b0;
      init_q      <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
    end else begin
      rd_ack_q <= 1'b0;
      init_q   <= 1'b0;
      push_q   <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (spi_rd_data_available) begin
            if (rx_opcode == OP_NOP) begin
              rd_ack_q <= 1'b1;
              state_q  <= RX_WAIT_LOW;
            end else if (rx_opcode == OP_INIT) begin
              rd_ack_q <= 1'b1;
              init_q   <= 1'b1;
              state_q  <= RX_WAIT_LOW;
            end else if (is_queued_opcode(rx_opcode) && (cmd_count != CMD_FULL)) begin
              rd_ack_q    <= 1'b1;
              push_q      <= 1'b1;
              push_word_q <= spi_rd_data;
              state_q     <= RX_WAIT_LOW;
            end
          end
        end
        RX_WAIT_LOW: begin
          if (!spi_rd_data_available) begin
            state_q <= RX_IDLE;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  sync_fifo #(.WIDTH(RX_WORD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (init_q),
    .push_i      (push_q),
    .push_data_i (push_word_q),
    .pop_i       (cmd_valid && cmd_ready),
    .head_o      (cmd_head),
    .count_o     (cmd_count)
  );

  assign cmd_valid   = (cmd_count != '0);
  assign cmd_opcode  = cmd_head[OPCODE_W-1:0];
  assign cmd_payload = cmd_head[RX_WORD_W-1:OPCODE_W];

  sync_fifo #(.WIDTH(PAYLOAD_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (init_q),
    .push_i      (rsp_valid && rsp_ready),
    .push_data_i (rsp_data),
    .pop_i       (wr_en_d),
    .head_o      (rsp_head),
    .count_o     (rsp_count)
  );

  assign rsp_ready = (rsp_count != RSP_FULL);

  // Skipping a cycle after each strobe covers the slave's lag on buffer_free; no launch during a flush.
  assign wr_en_d = (rsp_count != '0) && spi_wr_buffer_free && !wr_en_q && !init_q;

  // TX strobe and data register; data holds between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      if (wr_en_d) begin
        wr_data_q <= rsp_head;
      end
    end
  end

  assign spi_rd_ack  = rd_ack_q;
  assign init_pulse  = init_q;
  assign spi_wr_en   = wr_en_q;
  assign spi_wr_data = wr_data_q;

endmodule

// File: tb/tb_spi_cmd_bridge.sv
// Directed self-checking bench for spi_cmd_bridge.
module tb_spi_cmd_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_rd_data_available;
  logic [31:0] spi_rd_data;
  logic        spi_rd_ack;
  logic        spi_wr_buffer_free;
  logic        spi_wr_en;
  logic [23:0] spi_wr_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [23:0] cmd_payload;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [23:0] rsp_data;
  logic        init_pulse;

  int checks = 0;
  int passes = 0;
  int ack_cnt = 0;
  int cyc = 0;
  logic [23:0] wr_log[$];
  int          wr_cyc[$];
  logic [31:0] pop_log[$];

  spi_cmd_bridge #(.CMD_DEPTH(4), .RSP_DEPTH(8)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .spi_rd_data_available (spi_rd_data_available),
    .spi_rd_data           (spi_rd_data),
    .spi_rd_ack            (spi_rd_ack),
    .spi_wr_buffer_free    (spi_wr_buffer_free),
    .spi_wr_en             (spi_wr_en),
    .spi_wr_data           (spi_wr_data),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_opcode            (cmd_opcode),
    .cmd_payload           (cmd_payload),
    .rsp_valid             (rsp_valid),
    .rsp_ready             (rsp_ready),
    .rsp_data              (rsp_data),
    .init_pulse            (init_pulse)
  );

  always #5 clk = ~clk;

  // Records strobes, pops and acks as seen just before each edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (spi_wr_en) begin
      wr_log.push_back(spi_wr_data);
      wr_cyc.push_back(cyc);
    end
    if (cmd_valid && cmd_ready) pop_log.push_back({cmd_payload, cmd_opcode});
    if (spi_rd_ack) ack_cnt = ack_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic send_word(input logic [31:0] w, output bit acked);
    acked = 1'b0;
    spi_rd_data = w;
    spi_rd_data_available = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (spi_rd_ack) begin
        acked = 1'b1;
        break;
      end
    end
    spi_rd_data_available = 1'b0;
    step();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ack"},      {31'd0, spi_rd_ack}, 32'd0);
    check({pfx, "_wr_en"},    {31'd0, spi_wr_en},  32'd0);
    check({pfx, "_wr_data"},  {8'd0, spi_wr_data}, 32'd0);
    check({pfx, "_cmd_valid"},{31'd0, cmd_valid},  32'd0);
    check({pfx, "_opcode"},   {24'd0, cmd_opcode}, 32'd0);
    check({pfx, "_payload"},  {8'd0, cmd_payload}, 32'd0);
    check({pfx, "_rsp_ready"},{31'd0, rsp_ready},  32'd1);
    check({pfx, "_init"},     {31'd0, init_pulse}, 32'd0);
  endtask

  initial begin
    bit ok;
    int acks_before;
    reset = 1'b1;
    spi_rd_data_available = 1'b0;
    spi_rd_data = 32'd0;
    spi_wr_buffer_free = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data = 24'd0;
    repeat (3) step();
    check_reset_outputs("rst");
    reset = 1'b0;
    step();

    // Single capture of a held word, 2-cycle command latency.
    ack_cnt = 0;
    spi_rd_data = 32'h00ABCD04;
    spi_rd_data_available = 1'b1;
    step();
    check("t1_ack_rise", {31'd0, spi_rd_ack}, 32'd1);
    check("t1_valid_early", {31'd0, cmd_valid}, 32'd0);
    step();
    check("t1_ack_fall", {31'd0, spi_rd_ack}, 32'd0);
    check("t1_valid", {31'd0, cmd_valid}, 32'd1);
    check("t1_opcode", {24'd0, cmd_opcode}, 32'h04);
    check("t1_payload", {8'd0, cmd_payload}, 32'h00ABCD);
    repeat (3) step();
    spi_rd_data_available = 1'b0;
    step();
    check("t1_ack_count", ack_cnt, 1);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    check("t1_popped", {31'd0, cmd_valid}, 32'd0);

    // NOP is acked and filtered.
    send_word(32'h00000000, ok);
    check("t2_nop_ack", {31'd0, ok}, 32'd1);
    step();
    check("t2_nop_not_pushed", {31'd0, cmd_valid}, 32'd0);

    // INIT with 3 commands and a response queued.
    send_word(32'h00000102, ok);
    send_word(32'h00000203, ok);
    send_word(32'h00000305, ok);
    rsp_valid = 1'b1;
    rsp_data = 24'h0000AA;
    step();
    rsp_valid = 1'b0;
    wr_log.delete();
    check("t2_pre_valid", {31'd0, cmd_valid}, 32'd1);
    spi_rd_data = 32'h00000001;
    spi_rd_data_available = 1'b1;
    step();
    check("t2_init_ack", {31'd0, spi_rd_ack}, 32'd1);
    check("t2_init_pulse", {31'd0, init_pulse}, 32'd1);
    step();
    check("t2_init_pulse_1cyc", {31'd0, init_pulse}, 32'd0);
    check("t2_flushed", {31'd0, cmd_valid}, 32'd0);
    spi_rd_data_available = 1'b0;
    spi_wr_buffer_free = 1'b1;
    repeat (6) step();
    check("t2_no_tx", wr_log.size(), 0);
    check("t2_init_not_pushed", {31'd0, cmd_valid}, 32'd0);

    // Command backpressure at depth 4.
    pop_log.delete();
    for (int i = 1; i <= 4; i++) begin
      send_word({8'h00, 8'(i), 8'h11, 8'h06}, ok);
      check("t3_ack", {31'd0, ok}, 32'd1);
    end
    acks_before = ack_cnt;
    spi_rd_data = 32'h00005506;
    spi_rd_data_available = 1'b1;
    repeat (4) step();
    check("t3_full_no_ack", ack_cnt, acks_before);
    cmd_ready = 1'b1;
    step();
    check("t3_pop_cycle_no_ack", {31'd0, spi_rd_ack}, 32'd0);
    cmd_ready = 1'b0;
    step();
    check("t3_ack_after_pop", {31'd0, spi_rd_ack}, 32'd1);
    spi_rd_data_available = 1'b0;
    step();
    cmd_ready = 1'b1;
    repeat (6) step();
    cmd_ready = 1'b0;
    check("t3_pop_count", pop_log.size(), 5);
    for (int i = 0; i < 4; i++) begin
      if (i < pop_log.size()) check("t3_pop_order", pop_log[i], {8'h00, 8'(i + 1), 8'h11, 8'h06});
    end
    if (pop_log.size() > 4) check("t3_pop_fifth", pop_log[4], 32'h00005506);
    check("t3_empty", {31'd0, cmd_valid}, 32'd0);

    // Three back-to-back responses, strobes 2 cycles apart.
    wr_log.delete();
    wr_cyc.delete();
    rsp_valid = 1'b1;
    rsp_data = 24'h000001;
    step();
    check("t4_no_strobe_yet", {31'd0, spi_wr_en}, 32'd0);
    rsp_data = 24'h000002;
    step();
    check("t4_first_strobe", {31'd0, spi_wr_en}, 32'd1);
    check("t4_first_data", {8'd0, spi_wr_data}, 32'h000001);
    rsp_data = 24'h000003;
    step();
    rsp_valid = 1'b0;
    repeat (8) step();
    check("t4_count", wr_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < wr_log.size()) check("t4_data", {8'd0, wr_log[i]}, i + 1);
    end
    if (wr_cyc.size() == 3) begin
      check("t4_gap1", wr_cyc[1] - wr_cyc[0], 2);
      check("t4_gap2", wr_cyc[2] - wr_cyc[1], 2);
    end
    check("t4_hold", {8'd0, spi_wr_data}, 32'h000003);

    // Response FIFO fills while the slave is busy, then drains in order.
    spi_wr_buffer_free = 1'b0;
    step();
    wr_log.delete();
    for (int i = 0; i < 8; i++) begin
      check("t5_ready_while_filling", {31'd0, rsp_ready}, 32'd1);
      rsp_valid = 1'b1;
      rsp_data = 24'h000010 + 24'(i);
      step();
    end
    check("t5_full", {31'd0, rsp_ready}, 32'd0);
    rsp_data = 24'h000BAD;
    step();
    rsp_valid = 1'b0;
    check("t5_no_strobe", wr_log.size(), 0);
    spi_wr_buffer_free = 1'b1;
    repeat (20) step();
    check("t5_drain_count", wr_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < wr_log.size()) check("t5_drain_data", {8'd0, wr_log[i]}, 32'h10 + i);
    end
    check("t5_ready_again", {31'd0, rsp_ready}, 32'd1);

    // Reset mid-drain with a pending slave word.
    send_word(32'h00000A06, ok);
    send_word(32'h00000B06, ok);
    spi_wr_buffer_free = 1'b0;
    rsp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rsp_data = 24'h000070 + 24'(i);
      step();
    end
    rsp_valid = 1'b0;
    spi_wr_buffer_free = 1'b1;
    step();
    step();
    reset = 1'b1;
    spi_rd_data = 32'h00007707;
    spi_rd_data_available = 1'b1;
    step();
    check_reset_outputs("t6");
    reset = 1'b0;
    wr_log.delete();
    step();
    check("t6_pending_ack", {31'd0, spi_rd_ack}, 32'd1);
    step();
    check("t6_cmd_valid", {31'd0, cmd_valid}, 32'd1);
    check("t6_cmd_word", {cmd_payload, cmd_opcode}, 32'h00007707);
    spi_rd_data_available = 1'b0;
    repeat (6) step();
    check("t6_rsp_flushed", wr_log.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
